uart_tx_sched: RTL and testbench

Word-level transmit scheduler for the UART. It sits between the CPU store path and the byte serializer. CPU writes of a 32-bit word plus a 2-bit byte count are queued in a small FIFO. The block then feeds the serializer one byte at a time, LSB byte first, using a load/ready handshake. This replaces ad-hoc multi-clock byte sequencing with a single-clock FSM and adds back-pressure and overflow reporting.

---
 rtl/uart_pkg.sv | 25 ++
 rtl/uart_tx_fifo.sv | 56 +++++
 rtl/uart_tx_sched.sv | 108 ++++++++++
 tb/tb_uart_tx_sched.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: scheduler state encoding, byte-count codes and
// the transmit FIFO entry layout.
package uart_pkg;

   localparam int UART_WORD_W = 32;

   localparam logic [1:0] UART_1B = 2'b00;
   localparam logic [1:0] UART_2B = 2'b01;
   localparam logic [1:0] UART_3B = 2'b10;
   localparam logic [1:0] UART_4B = 2'b11;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      FETCH = 3'd1,
      SEND  = 3'd2,
      GUARD = 3'd3,
      WAIT  = 3'd4
   } tx_sched_state_t;

   typedef struct packed {
      logic [1:0]             ctrl;
      logic [UART_WORD_W-1:0] data;
   } tx_entry_t;

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO; full/empty derive from the occupancy counter so the
// pointers can wrap naturally at $clog2(DEPTH) bits.
module uart_tx_fifo #(
   parameter int W     = 34,
   parameter int DEPTH = 4
) (
   input  logic                     i_clk,
   input  logic                     i_reset,
   input  logic                     i_push,
   input  logic                     i_pop,
   input  logic [W-1:0]             i_wdata,
   output logic [W-1:0]             o_rdata,
   output logic [$clog2(DEPTH):0]   o_level,
   output logic                     o_full,
   output logic                     o_empty
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [AW:0]   r_level;
   logic          w_push;
   logic          w_pop;

   assign o_full  = (r_level == (AW+1)'(DEPTH));
   assign o_empty = (r_level == '0);
   assign o_level = r_level;
   assign o_rdata = r_mem[r_rd_ptr];

   // A pop in the same cycle frees a slot, so a push into a full FIFO is legal then.
   assign w_pop  = i_pop && !o_empty;
   assign w_push = i_push && (!o_full || w_pop);

   always_ff @(posedge i_clk) begin
      if (w_push) r_mem[r_wr_ptr] <= i_wdata;
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         case ({w_push, w_pop})
            2'b10:   r_level <= r_level + (AW+1)'(1);
            2'b01:   r_level <= r_level - (AW+1)'(1);
            default: r_level <= r_level;
         endcase
      end
   end

endmodule

// File: rtl/uart_tx_sched.sv
// UART word-level transmit scheduler: queues CPU words and feeds the byte
// serializer LSB byte first over a load/ready handshake.
module uart_tx_sched
   import uart_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                   i_clk,
   input  logic                   i_reset,
   input  logic                   i_wr_en,
   input  logic [UART_WORD_W-1:0] i_wr_data,
   input  logic [1:0]             i_wr_ctrl,
   output logic                   o_fifo_full,
   output logic [$clog2(DEPTH):0] o_fifo_level,
   output logic                   o_overflow,
   output logic [7:0]             o_tx_byte,
   output logic                   o_tx_load,
   input  logic                   i_tx_ready,
   output logic                   o_busy,
   output logic                   o_word_done
);

   tx_sched_state_t        r_state;
   tx_entry_t              w_wentry;
   tx_entry_t              w_head;
   logic [UART_WORD_W-1:0] r_word;
   logic [1:0]             r_last_idx;
   logic [1:0]             r_idx;
   logic                   r_overflow;
   logic [7:0]             r_tx_byte;
   logic                   r_tx_load;
   logic                   r_word_done;
   logic                   w_pop;
   logic                   w_full;
   logic                   w_empty;

   assign w_wentry = '{ctrl: i_wr_ctrl, data: i_wr_data};
   assign w_pop    = (r_state == FETCH);

   uart_tx_fifo #(
      .W     ($bits(tx_entry_t)),
      .DEPTH (DEPTH)
   ) u_fifo (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_push  (i_wr_en),
      .i_pop   (w_pop),
      .i_wdata (w_wentry),
      .o_rdata (w_head),
      .o_level (o_fifo_level),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   assign o_fifo_full = w_full;
   assign o_overflow  = r_overflow;
   assign o_tx_byte   = r_tx_byte;
   assign o_tx_load   = r_tx_load;
   assign o_word_done = r_word_done;
   assign o_busy      = (r_state != IDLE) || !w_empty;

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset)                            r_overflow <= 1'b0;
      else if (i_wr_en && w_full && !w_pop)   r_overflow <= 1'b1;
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state     <= IDLE;
         r_word      <= '0;
         r_last_idx  <= '0;
         r_idx       <= '0;
         r_tx_byte   <= 8'h00;
         r_tx_load   <= 1'b0;
         r_word_done <= 1'b0;
      end else begin
         r_tx_load   <= 1'b0;
         r_word_done <= 1'b0;
         case (r_state)
            IDLE: if (!w_empty) r_state <= FETCH;
            FETCH: begin
               r_word     <= w_head.data;
               r_last_idx <= w_head.ctrl;
               r_idx      <= '0;
               r_state    <= SEND;
            end
            SEND: if (i_tx_ready) begin
               r_tx_load <= 1'b1;
               r_tx_byte <= r_word[{r_idx, 3'b000} +: 8];
               r_state   <= GUARD;
            end
            // Serializer may still show ready from before it saw the load.
            GUARD: r_state <= WAIT;
            WAIT: if (i_tx_ready) begin
               if (r_idx != r_last_idx) begin
                  r_idx   <= r_idx + 2'd1;
                  r_state <= SEND;
               end else begin
                  r_word_done <= 1'b1;
                  r_state     <= w_empty ? IDLE : FETCH;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched with a negedge serializer model.
module tb_uart_tx_sched;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        wr_en = 1'b0;
   logic [31:0] wr_data = '0;
   logic [1:0]  wr_ctrl = '0;
   logic        fifo_full;
   logic [2:0]  fifo_level;
   logic        overflow;
   logic [7:0]  tx_byte;
   logic        tx_load;
   logic        tx_ready = 1'b0;
   logic        busy;
   logic        word_done;

   int n_tests = 0;
   int n_fail  = 0;

   // serializer model / monitor state (written only by the monitor process)
   int          cyc = 0, loads = 0, dones = 0, viol = 0, hold = 0;
   int          rise_cyc = 0, done_cyc = 0;
   logic        prev_load = 1'b0;
   logic [7:0]  bq[$];
   // serializer mode (written only by the test tasks)
   int          ser_mode = 0;
   int          ser_hold = 10;
   bit          ser_rand = 1'b0;
   logic        ready_force = 1'b0;

   uart_tx_sched #(.DEPTH(4)) dut (
      .i_clk        (clk),
      .i_reset      (reset),
      .i_wr_en      (wr_en),
      .i_wr_data    (wr_data),
      .i_wr_ctrl    (wr_ctrl),
      .o_fifo_full  (fifo_full),
      .o_fifo_level (fifo_level),
      .o_overflow   (overflow),
      .o_tx_byte    (tx_byte),
      .o_tx_load    (tx_load),
      .i_tx_ready   (tx_ready),
      .o_busy       (busy),
      .o_word_done  (word_done)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   always @(negedge clk) begin
      cyc++;
      if (tx_load) begin
         bq.push_back(tx_byte);
         loads++;
         if (!tx_ready || prev_load) viol++;
      end
      prev_load = tx_load;
      if (word_done) begin
         dones++;
         done_cyc = cyc;
      end
      if (ser_mode == 0) tx_ready = ready_force;
      else if (tx_load) begin
         tx_ready = 1'b0;
         hold = ser_rand ? int'($urandom_range(20, 1)) : ser_hold;
      end else if (hold > 0) begin
         hold--;
         if (hold == 0) begin
            tx_ready = 1'b1;
            rise_cyc = cyc;
         end
      end else if (!tx_ready) begin
         tx_ready = 1'b1;
         rise_cyc = cyc;
      end
   end

   // call aligned to a negedge; returns at the next negedge
   task automatic wr(input logic [31:0] d, input logic [1:0] c);
      wr_en = 1'b1; wr_data = d; wr_ctrl = c;
      @(negedge clk);
      wr_en = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic wait_idle(input int budget, input string tag);
      int n = 0;
      @(negedge clk);
      while (busy && n < budget) begin
         @(negedge clk);
         n++;
      end
      #1;
      n_tests++;
      if (busy) begin
         n_fail++;
         $display("FAIL %s_idle_timeout busy=%0b after %0d cycles, required 0", tag, busy, n);
      end
   endtask

   task automatic check_bytes(input int base, input logic [7:0] exp[$], input string tag);
      n_tests++;
      if (bq.size() - base != exp.size()) begin
         n_fail++;
         $display("FAIL %s_count got=%0d required=%0d", tag, bq.size() - base, exp.size());
      end
      for (int i = 0; i < exp.size(); i++) begin
         if (base + i < bq.size()) begin
            n_tests++;
            if (bq[base+i] !== exp[i]) begin
               n_fail++;
               $display("FAIL %s_byte%0d got=%02h required=%02h", tag, i, bq[base+i], exp[i]);
            end
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(negedge clk);
      n_tests += 7;
      if (fifo_level !== 3'd0) begin n_fail++; $display("FAIL rst_level got=%0d required=0", fifo_level); end
      if (fifo_full !== 1'b0)  begin n_fail++; $display("FAIL rst_full got=%0b required=0", fifo_full); end
      if (overflow !== 1'b0)   begin n_fail++; $display("FAIL rst_overflow got=%0b required=0", overflow); end
      if (tx_byte !== 8'h00)   begin n_fail++; $display("FAIL rst_tx_byte got=%02h required=00", tx_byte); end
      if (tx_load !== 1'b0)    begin n_fail++; $display("FAIL rst_tx_load got=%0b required=0", tx_load); end
      if (busy !== 1'b0)       begin n_fail++; $display("FAIL rst_busy got=%0b required=0", busy); end
      if (word_done !== 1'b0)  begin n_fail++; $display("FAIL rst_word_done got=%0b required=0", word_done); end
      reset = 1'b0;
   endtask

   task automatic test_four_byte();
      int b0, l0, d0;
      logic [7:0] exp[$] = '{8'hD4, 8'hC3, 8'hB2, 8'hA1};
      ser_mode = 1; ser_rand = 1'b0; ser_hold = 10;
      repeat (2) @(negedge clk);
      #1; b0 = bq.size(); l0 = loads; d0 = dones;
      @(negedge clk);
      wr(32'hA1B2C3D4, 2'b11);
      repeat (2) @(negedge clk);
      n_tests++;
      if (tx_load !== 1'b0) begin n_fail++; $display("FAIL lat_early tx_load=%0b required=0", tx_load); end
      @(negedge clk);
      n_tests += 2;
      if (tx_load !== 1'b1) begin n_fail++; $display("FAIL lat_first tx_load=%0b required=1", tx_load); end
      if (tx_byte !== 8'hD4) begin n_fail++; $display("FAIL lat_byte got=%02h required=D4", tx_byte); end
      wait_idle(500, "four");
      check_bytes(b0, exp, "four");
      n_tests += 4;
      if (loads - l0 != 4) begin n_fail++; $display("FAIL four_loads got=%0d required=4", loads - l0); end
      if (dones - d0 != 1) begin n_fail++; $display("FAIL four_done got=%0d required=1", dones - d0); end
      if (busy !== 1'b0)   begin n_fail++; $display("FAIL four_busy got=%0b required=0", busy); end
      if (tx_byte !== 8'hA1) begin n_fail++; $display("FAIL four_hold_byte got=%02h required=A1", tx_byte); end
   endtask

   task automatic test_one_byte();
      int b0, l0, d0;
      logic [7:0] exp[$] = '{8'h34};
      b0 = bq.size(); l0 = loads; d0 = dones;
      @(negedge clk);
      wr(32'h00001234, 2'b00);
      wait_idle(500, "one");
      check_bytes(b0, exp, "one");
      n_tests += 3;
      if (loads - l0 != 1) begin n_fail++; $display("FAIL one_loads got=%0d required=1", loads - l0); end
      if (dones - d0 != 1) begin n_fail++; $display("FAIL one_done got=%0d required=1", dones - d0); end
      if (done_cyc - rise_cyc != 1) begin
         n_fail++; $display("FAIL one_done_delay got=%0d required=1", done_cyc - rise_cyc);
      end
   endtask

   task automatic test_overflow();
      int b0, l0;
      logic [7:0] exp[$] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14};
      ser_mode = 0; ready_force = 1'b0;
      @(negedge clk);
      do_reset();
      #1; b0 = bq.size(); l0 = loads;
      @(negedge clk);
      // first word is popped into the holding registers, so five fill the FIFO
      for (int i = 0; i < 5; i++) wr(32'h10 + i, 2'b00);
      n_tests += 3;
      if (fifo_full !== 1'b1)   begin n_fail++; $display("FAIL ovf_full got=%0b required=1", fifo_full); end
      if (fifo_level !== 3'd4)  begin n_fail++; $display("FAIL ovf_level got=%0d required=4", fifo_level); end
      if (overflow !== 1'b0)    begin n_fail++; $display("FAIL ovf_early got=%0b required=0", overflow); end
      wr(32'h15, 2'b00);
      n_tests += 2;
      if (overflow !== 1'b1)    begin n_fail++; $display("FAIL ovf_set got=%0b required=1", overflow); end
      if (fifo_level !== 3'd4)  begin n_fail++; $display("FAIL ovf_level_drop got=%0d required=4", fifo_level); end
      ser_mode = 1; ser_hold = 3;
      wait_idle(1000, "ovf");
      check_bytes(b0, exp, "ovf");
      n_tests += 3;
      if (overflow !== 1'b1)   begin n_fail++; $display("FAIL ovf_sticky got=%0b required=1", overflow); end
      if (loads - l0 != 5)     begin n_fail++; $display("FAIL ovf_loads got=%0d required=5", loads - l0); end
      if (fifo_level !== 3'd0) begin n_fail++; $display("FAIL ovf_drained got=%0d required=0", fifo_level); end
   endtask

   task automatic test_fetch_full();
      int b0;
      bit found = 1'b0;
      logic [7:0] exp[$] = '{8'h20, 8'h21, 8'h22, 8'h23, 8'h24, 8'h25};
      ser_mode = 0; ready_force = 1'b0;
      @(negedge clk);
      do_reset();
      #1; b0 = bq.size();
      @(negedge clk);
      for (int i = 0; i < 5; i++) wr(32'h20 + i, 2'b00);
      ready_force = 1'b1;
      for (int k = 0; k < 50; k++) begin
         @(negedge clk);
         if (word_done) begin found = 1'b1; break; end
      end
      n_tests++;
      if (!found) begin n_fail++; $display("FAIL ff_wait word_done=0 after 50 cycles, required 1"); end
      n_tests++;
      if (fifo_full !== 1'b1) begin n_fail++; $display("FAIL ff_pre_full got=%0b required=1", fifo_full); end
      wr_en = 1'b1; wr_data = 32'h25; wr_ctrl = 2'b00; ready_force = 1'b0;
      @(negedge clk);
      wr_en = 1'b0;
      n_tests += 2;
      if (fifo_level !== 3'd4) begin n_fail++; $display("FAIL ff_level got=%0d required=4", fifo_level); end
      if (overflow !== 1'b0)   begin n_fail++; $display("FAIL ff_overflow got=%0b required=0", overflow); end
      ser_mode = 1; ser_hold = 3;
      wait_idle(1000, "ff");
      check_bytes(b0, exp, "ff");
      n_tests++;
      if (overflow !== 1'b0) begin n_fail++; $display("FAIL ff_overflow_end got=%0b required=0", overflow); end
   endtask

   task automatic test_reset_mid();
      int l0, l1;
      bit found = 1'b0;
      ser_mode = 1; ser_rand = 1'b0; ser_hold = 10;
      @(negedge clk);
      do_reset();
      #1; l0 = loads;
      @(negedge clk);
      wr(32'h11223344, 2'b11);
      wr(32'h55667788, 2'b00);
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         #1;
         if (loads - l0 == 2) begin found = 1'b1; break; end
      end
      n_tests += 2;
      if (!found) begin n_fail++; $display("FAIL rm_wait loads=%0d required=2", loads - l0); end
      if (tx_load !== 1'b1) begin n_fail++; $display("FAIL rm_pre_load got=%0b required=1", tx_load); end
      reset = 1'b1;
      #1;
      n_tests += 4;
      if (tx_load !== 1'b0)    begin n_fail++; $display("FAIL rm_load got=%0b required=0", tx_load); end
      if (fifo_level !== 3'd0) begin n_fail++; $display("FAIL rm_level got=%0d required=0", fifo_level); end
      if (busy !== 1'b0)       begin n_fail++; $display("FAIL rm_busy got=%0b required=0", busy); end
      if (tx_byte !== 8'h00)   begin n_fail++; $display("FAIL rm_byte got=%02h required=00", tx_byte); end
      @(negedge clk);
      reset = 1'b0;
      #1; l1 = loads;
      repeat (60) @(negedge clk);
      #1;
      n_tests += 2;
      if (loads != l1)   begin n_fail++; $display("FAIL rm_no_loads got=%0d required=0", loads - l1); end
      if (busy !== 1'b0) begin n_fail++; $display("FAIL rm_busy_after got=%0b required=0", busy); end
   endtask

   task automatic test_random_ready();
      int b0, v0, d0;
      logic [7:0] exp[$] = '{8'hEF, 8'hBE, 8'hAD, 8'hFE, 8'hCA, 8'h10, 8'h32, 8'h54, 8'h76};
      ser_mode = 1; ser_rand = 1'b1;
      @(negedge clk);
      #1; b0 = bq.size(); v0 = viol; d0 = dones;
      @(negedge clk);
      wr(32'hDEADBEEF, 2'b10);
      wr(32'h0000CAFE, 2'b01);
      wr(32'h76543210, 2'b11);
      wait_idle(2000, "rnd");
      check_bytes(b0, exp, "rnd");
      n_tests += 2;
      if (viol != v0)      begin n_fail++; $display("FAIL rnd_handshake violations=%0d required=0", viol - v0); end
      if (dones - d0 != 3) begin n_fail++; $display("FAIL rnd_done got=%0d required=3", dones - d0); end
   endtask

   initial begin
      test_reset();
      test_four_byte();
      test_one_byte();
      test_overflow();
      test_fetch_full();
      test_reset_mid();
      test_random_ready();
      n_tests++;
      if (viol != 0) begin n_fail++; $display("FAIL handshake_total violations=%0d required=0", viol); end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
